// File: rtl/ksa_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ksa_pkg
// Description : Shared constants, generate/propagate type and helpers for the
//               pipelined Kogge-Stone adder/subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
package ksa_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    function automatic int nseg(input int width, input int seg_w);
        return width / seg_w;
    endfunction

    // Prefix operator: hi covers the more significant span.
    function automatic gp_t gp_merge(input gp_t hi, input gp_t lo);
        gp_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p & lo.p;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ksa_segment.sv
`default_nettype none
// ============================================================================
// Module      : ksa_segment
// Description : Combinational SEG_W-bit Kogge-Stone adder with carry-in and
//               carry-into-MSB output.
// Revision    : 1.0 - initial release
// ============================================================================
module ksa_segment
    import ksa_pkg::*;
#(
    parameter int SEG_W = 8
) (
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             ci,
    output logic [SEG_W-1:0] s,
    output logic             co,
    output logic             c_msb
);

    localparam int c_lvls = $clog2(SEG_W);

    gp_t              w_gp0 [SEG_W];
    gp_t              w_gpf [SEG_W];
    logic [SEG_W:0]   w_c;

    for (genvar i = 0; i < SEG_W; i++) begin : g_bit
        assign w_gp0[i] = '{g: a[i] & b[i], p: a[i] ^ b[i]};
    end

    for (genvar l = 0; l < c_lvls; l++) begin : g_lvl
        localparam int c_dist = 1 << l;
        gp_t w_prev [SEG_W];
        gp_t w_gp   [SEG_W];

        if (l == 0) begin : g_first
            assign w_prev = w_gp0;
        end else begin : g_next
            assign w_prev = g_lvl[l-1].w_gp;
        end

        for (genvar i = 0; i < SEG_W; i++) begin : g_node
            if (i >= c_dist) begin : g_merge
                assign w_gp[i] = gp_merge(w_prev[i], w_prev[i-c_dist]);
            end else begin : g_pass
                assign w_gp[i] = w_prev[i];
            end
        end
    end

    if (c_lvls == 0) begin : g_flat
        assign w_gpf = w_gp0;
    end else begin : g_tree
        assign w_gpf = g_lvl[c_lvls-1].w_gp;
    end

    // Group terms span bit 0..i, so the segment carry-in folds in once here.
    assign w_c[0] = ci;
    for (genvar i = 0; i < SEG_W; i++) begin : g_sum
        assign w_c[i+1] = w_gpf[i].g | (w_gpf[i].p & ci);
        assign s[i]     = w_gp0[i].p ^ w_c[i];
    end

    assign co    = w_c[SEG_W];
    assign c_msb = w_c[SEG_W-1];

endmodule
`default_nettype wire

// File: rtl/ksa_pipe_adder.sv
`default_nettype none
// ============================================================================
// Module      : ksa_pipe_adder
// Description : Pipelined segmented Kogge-Stone adder/subtractor, one segment
//               per stage, with valid/ready handshake and backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module ksa_pipe_adder
    import ksa_pkg::*;
#(
    parameter int WIDTH = 48,
    parameter int SEG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf
);

    localparam int c_nseg = nseg(WIDTH, SEG_W);

    if ((WIDTH % SEG_W) != 0 || WIDTH < SEG_W) begin : g_bad_cfg
        $error("ksa_pipe_adder: WIDTH must be a non-zero multiple of SEG_W");
    end

    logic             w_advance;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_ci_eff;

    assign w_advance = !out_valid || out_ready;
    assign in_ready  = w_advance;
    assign w_b_eff   = (sub == OP_SUB) ? ~b : b;
    assign w_ci_eff  = (sub == OP_SUB) ? ~ci : ci;

    for (genvar k = 0; k < c_nseg; k++) begin : g_stage
        localparam int c_in_w = (c_nseg - k) * SEG_W;
        localparam int c_s_w  = (k + 1) * SEG_W;

        logic [c_in_w-1:0] w_a_in;
        logic [c_in_w-1:0] w_b_in;
        logic              w_ci_in;
        logic              w_vld_in;
        logic [SEG_W-1:0]  w_sum;
        logic              w_co;
        logic              w_cmsb;
        logic [c_s_w-1:0]  w_s_nxt;
        logic              r_vld;
        logic              r_cy;
        logic [c_s_w-1:0]  r_s;

        ksa_segment #(
            .SEG_W (SEG_W)
        ) u_seg (
            .a     (w_a_in[SEG_W-1:0]),
            .b     (w_b_in[SEG_W-1:0]),
            .ci    (w_ci_in),
            .s     (w_sum),
            .co    (w_co),
            .c_msb (w_cmsb)
        );

        if (k == 0) begin : g_head
            assign w_a_in   = a;
            assign w_b_in   = w_b_eff;
            assign w_ci_in  = w_ci_eff;
            assign w_vld_in = in_valid;
            assign w_s_nxt  = w_sum;
        end else begin : g_body
            assign w_a_in   = g_stage[k-1].g_skew.r_a_hi;
            assign w_b_in   = g_stage[k-1].g_skew.r_b_hi;
            assign w_ci_in  = g_stage[k-1].r_cy;
            assign w_vld_in = g_stage[k-1].r_vld;
            // Finished lower segments ride along so s leaves the pipe whole.
            assign w_s_nxt  = {w_sum, g_stage[k-1].r_s};
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_vld <= 1'b0;
                r_cy  <= 1'b0;
                r_s   <= '0;
            end else if (w_advance) begin
                r_vld <= w_vld_in;
                r_cy  <= w_co;
                r_s   <= w_s_nxt;
            end
        end

        if (k < c_nseg - 1) begin : g_skew
            localparam int c_hi_w = c_in_w - SEG_W;
            logic [c_hi_w-1:0] r_a_hi;
            logic [c_hi_w-1:0] r_b_hi;
            logic              w_unused_cmsb;

            assign w_unused_cmsb = w_cmsb;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_a_hi <= '0;
                    r_b_hi <= '0;
                end else if (w_advance) begin
                    r_a_hi <= w_a_in[c_in_w-1:SEG_W];
                    r_b_hi <= w_b_in[c_in_w-1:SEG_W];
                end
            end
        end else begin : g_tail
            logic r_ovf;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_ovf <= 1'b0;
                end else if (w_advance) begin
                    r_ovf <= w_cmsb ^ w_co;
                end
            end
        end
    end

    assign out_valid = g_stage[c_nseg-1].r_vld;
    assign s         = g_stage[c_nseg-1].r_s;
    assign co        = g_stage[c_nseg-1].r_cy;
    assign ovf       = g_stage[c_nseg-1].g_tail.r_ovf;

endmodule
`default_nettype wire

// File: doc/ksa_pipe_adder.md
# ksa_pipe_adder

Parametrised, pipelined Kogge-Stone adder/subtractor for the ALU datapath. It splits a WIDTH-bit operation into NSEG = WIDTH/SEG_W segments, with one Kogge-Stone segment per pipeline stage. Carries are registered between stages, so throughput is one operation per clock at any width. It adds a subtract mode, a signed-overflow flag and a valid/ready handshake with backpressure, which makes it the drop-in registered replacement for the fixed-width chained adders.

## Interface
- WIDTH, 48: operand/result width; must be a multiple of SEG_W (elaboration error otherwise).
- SEG_W, 8: segment width; one Kogge-Stone segment and one pipeline stage per segment.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low; one clock domain, no synchroniser inside.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- ci  in  1  carry-in (add) / borrow-in (sub).
- sub  in  1  0 = add, 1 = subtract.
- out_valid  out  1  result beat present.
- out_ready  in  1  downstream accepts result.
- s  out  WIDTH  result.
- co  out  1  carry-out of MSB (sub mode: 1 = no borrow).
- ovf  out  1  two's-complement signed overflow.

## Operation
- Add (sub=0): s = a + b + ci, co = carry out of bit WIDTH-1.
- Sub (sub=1): s = a + ~b + ~ci, i.e. a − b − ci. co is the raw carry.
- ovf = carry into bit WIDTH-1 XOR co, in both modes.
- All arithmetic is modulo 2^WIDTH. No saturation.
- Stage k (0..NSEG-1) computes segment k, bits [k·SEG_W +: SEG_W]:
  - carry-in is the registered carry from stage k−1;
  - stage 0 uses the effective carry-in (ci, or ~ci when sub=1).
- Upper operand segments (with b already conditionally inverted) travel through skew registers until their stage.
- Finished lower result segments travel through de-skew registers, so s is presented whole.
- Each stage holds a valid bit. Bubbles propagate and are not collapsed.
- Handshake:
  - advance = !out_valid || out_ready.
  - in_ready = advance, combinational, with no dependence on in_valid.
  - A beat is accepted when in_valid && in_ready.
  - Every pipeline register, valid bits included, loads only when advance = 1. Otherwise it holds.
  - A result is consumed when out_valid && out_ready.
  - Accepting and consuming in the same cycle is legal and keeps full throughput.
- Results leave in acceptance order, with no loss and no duplication.
- s, co and ovf are stable while out_valid && !out_ready.

## Timing
- Reset (rst low, asynchronous):
  - all stage valid bits = 0;
  - out_valid = 0, s = 0, co = 0, ovf = 0;
  - in_ready = 1 (follows from out_valid = 0);
  - skew and de-skew data registers cleared to 0.
- Reset asserted mid-operation discards every in-flight beat. None appears after release.
- Latency: NSEG cycles from the accepting edge to out_valid, with out_ready held high.
  - Default configuration: 6 cycles.
  - SEG_W = WIDTH: 1 cycle, a single registered stage.
- Stall: while out_valid && !out_ready the whole pipe freezes and in_ready = 0.
- Critical path: one SEG_W-bit Kogge-Stone tree plus carry-in merge plus register. It is independent of WIDTH.

## Structure
- Package ksa_pkg:
  - OP_ADD = 1'b0 and OP_SUB = 1'b1 constants;
  - function nseg(WIDTH, SEG_W);
  - generate/propagate pair typedef, used by the segment.
- Sub-module ksa_segment #(SEG_W): combinational Kogge-Stone adder with log2(SEG_W) prefix levels. Ports a, b, ci, s, co, plus c_msb (carry into the segment MSB, used for ovf in the top segment).
- Top level: a generate loop of NSEG ksa_segment instances, the per-stage valid/carry registers and the triangular skew/de-skew register arrays. Expected size is roughly 200–300 lines of RTL.

## Test plan
Default parameters unless noted; out_ready = 1 unless noted.

- **Carry across one segment:** a = 48'h0000_0000_00FF, b = 1, ci = 0, sub = 0 → s = 48'h0000_0000_0100, co = 0, ovf = 0. out_valid rises exactly 6 cycles after acceptance.
- **Carry through every segment:** a = 48'hFFFF_FFFF_FFFF, b = 0, ci = 1 → s = 0, co = 1, ovf = 0.
- **Subtract:** a = 5, b = 7, ci = 0, sub = 1 → s = 48'hFFFF_FFFF_FFFE, co = 0, ovf = 0. Then a = 7, b = 5, sub = 1 → s = 2, co = 1.
- **Signed overflow:** a = 48'h7FFF_FFFF_FFFF, b = 1, add → s = 48'h8000_0000_0000, co = 0, ovf = 1.
- **Backpressure:** 200 back-to-back random beats (random sub/ci) with out_ready pseudo-random at 50%. Required:
  - results match the reference model, in order, with none lost or duplicated;
  - in_ready == !(out_valid && !out_ready) every cycle;
  - outputs held stable during stalls;
  - repeat with WIDTH = 32, SEG_W = 4 (latency 8) and with WIDTH = SEG_W = 16 (latency 1).
- **Reset mid-operation:** accept 3 beats, drive rst low asynchronously mid-cycle → out_valid = 0, s = co = ovf = 0 immediately. After release, no result appears until a new beat is accepted, and that beat's result arrives 6 cycles later.
